mux_b_operand_sel: RTL and testbench
====================================

// Module: mux_b_operand_sel
// PURPOSE
//  Parametrised successor of the datapath operand-B mux. Selects one of NUM_SRC operand sources
//  (immediate/ext, data memory, others) and registers the result into the ALU B-operand stage.
//  Handles data-memory read latency with a wait FSM and a valid/ready handshake on both sides.
//  Sits between the control unit (request side) and the ALU operand register (result side).
// PARAMETERS
//  DATA_WIDTH   11  operand width in bits
//  NUM_SRC      4   number of operand sources (>=2)
//  MEM_SRC      1   source index that is the data memory (0..NUM_SRC-1)
//  MEM_LATENCY  1   cycles from mem_rd_en pulse to valid memory data (0 = combinational memory)
//  SEL_WIDTH    $clog2(NUM_SRC) (localparam, min 1)
// PORTS
//  clk        in   1                    rising-edge clock
//  rst_n      in   1                    asynchronous reset, active low
//  src_in     in   NUM_SRC*DATA_WIDTH   packed sources; src i at [i*DATA_WIDTH +: DATA_WIDTH]
//  sel_B      in   SEL_WIDTH            source index, sampled on request acceptance
//  req_valid  in   1                    control requests an operand load
//  req_ready  out  1                    block can accept a request this cycle
//  mem_rd_en  out  1                    one-cycle pulse: data-memory read strobe
//  mux_B_out  out  DATA_WIDTH           registered operand
//  out_valid  out  1                    mux_B_out holds a fresh operand
//  out_ready  in   1                    consumer takes the operand
//  sel_err    out  1                    sticky out-of-range select flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, mux_B_out=0, out_valid=0, mem_rd_en=0, sel_err=0, count=0.
//    req_ready=1 (combinational from IDLE). Reset mid-WAIT_MEM discards the pending load;
//    no late capture after release.
//  - States: IDLE, WAIT_MEM, HOLD.
//  - req_ready = (state==IDLE) | (state==HOLD & out_ready). Acceptance = req_valid & req_ready.
//  - On acceptance, sel_B != MEM_SRC, or MEM_LATENCY==0:
//    capture src_in[sel_B] into mux_B_out at that edge -> HOLD (latency 1 cycle).
//  - On acceptance, sel_B==MEM_SRC and MEM_LATENCY>0: mem_rd_en=1 in the same cycle
//    (combinational from the acceptance), count<=MEM_LATENCY-1 -> WAIT_MEM.
//  - WAIT_MEM: req_ready=0. count==0 -> capture src_in[MEM_SRC] -> HOLD, else count--.
//    Memory data is therefore captured at acceptance edge + MEM_LATENCY.
//  - HOLD: out_valid=1, mux_B_out stable regardless of src_in changes.
//    - out_ready & no acceptance -> IDLE, out_valid=0 next cycle.
//    - out_ready & acceptance -> back-to-back: new request processed as from IDLE.
//  - mux_B_out updates only on capture; it retains its value in IDLE.
//  - Select arithmetic is unsigned. The index is compared against NUM_SRC only when NUM_SRC < 2**SEL_WIDTH.
// CONFIGURATION
//  MUX_B_SEL_CHECK_EN defined:
//    - sel_B>=NUM_SRC on acceptance captures 0 -> HOLD.
//    - sel_err is set and stays 1 until reset.
//  Undefined:
//    - out-of-range sel_B captures src_in[0] (ext source).
//    - sel_err is tied 0.
// STRUCTURE
//  - mux_b_pkg: state enum typedef (IDLE/WAIT_MEM/HOLD), default DATA_WIDTH constant,
//    function for source-slice extraction.
//  - Sub-module mux_b_lat_cnt: loadable down-counter ($clog2(MEM_LATENCY+1) bits, load/dec/zero flag).
//  - Top contains FSM, select logic, output register.
// TESTING (DATA_WIDTH=11, NUM_SRC=3, MEM_SRC=1, MEM_LATENCY=2, macro defined unless noted)
//  1. Reset asserted mid-sequence -> all outputs 0, req_ready=1 immediately, independent of clk.
//  2. sel_B=0, src0=11'b00001100100, req_valid 1 cycle:
//     -> next cycle mux_B_out=11'b00001100100, out_valid=1, no mem_rd_en.
//  3. sel_B=1, req at cycle t: mem_rd_en=1 at t only; src1=11'b11101001001 from t+2
//     -> out_valid rises after edge t+2 with that value; req_ready=0 during WAIT_MEM.
//  4. HOLD with out_ready=0 for 3 cycles while src0/src1 toggle
//     -> mux_B_out/out_valid unchanged; out_ready=1 -> out_valid=0 next cycle.
//  5. HOLD & out_ready & req_valid (sel_B=2, src2=11'h155)
//     -> accepted same cycle; next cycle mux_B_out=11'h155, out_valid stays 1.
//  6. sel_B=3 with macro -> mux_B_out=0, sel_err=1 sticky until rst_n=0;
//     without macro -> mux_B_out=src0, sel_err=0.
//     Also: rst_n pulse during WAIT_MEM -> no capture afterwards.

Source files
------------

// File: rtl/mux_b_pkg.sv
// Shared types and helpers for the ALU operand-B source mux.
// Holds the FSM state encoding and source-slice offset math.
package mux_b_pkg;

  localparam int DEF_DATA_WIDTH = 11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    HOLD     = 2'd2
  } state_e;

  function automatic int unsigned src_lsb(
    input int unsigned idx,
    input int unsigned width
  );
    return idx * width;
  endfunction

endpackage

// File: rtl/mux_b_lat_cnt.sv
// Loadable down-counter that times the data-memory read latency.
// zero_o flags the cycle in which memory data is due.
module mux_b_lat_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_b_operand_sel.sv
// ALU operand-B source mux with memory wait FSM and valid/ready handshakes.
// MUX_B_SEL_CHECK_EN: out-of-range selects capture 0 and set sticky sel_err.
module mux_b_operand_sel
  import mux_b_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_SRC     = 4,
  parameter int MEM_SRC     = 1,
  parameter int MEM_LATENCY = 1,
  localparam int SEL_WIDTH  = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_in,
  input  logic [SEL_WIDTH-1:0]          sel_B,
  input  logic                          req_valid,
  output logic                          req_ready,
  output logic                          mem_rd_en,
  output logic [DATA_WIDTH-1:0]         mux_B_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          sel_err
);

  localparam int CW = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam bit MEM_WAIT = (MEM_LATENCY > 0);
  localparam bit RNG_CHK = (NUM_SRC < (1 << SEL_WIDTH));
  localparam logic [CW-1:0] LD_VAL = CW'(MEM_WAIT ? MEM_LATENCY - 1 : 0);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [DATA_WIDTH-1:0] sel_val, mem_val;
  logic                  acc, is_mem, out_rng;
  logic                  cnt_ld, cnt_dec, cnt_zero;

  assign out_rng = RNG_CHK && (32'(sel_B) >= 32'(NUM_SRC));
  assign is_mem = MEM_WAIT && (sel_B == SEL_WIDTH'(MEM_SRC));
  assign mem_val = src_in[src_lsb(MEM_SRC, DATA_WIDTH) +: DATA_WIDTH];

  always_comb begin
    sel_val = src_in[src_lsb(32'(sel_B), DATA_WIDTH) +: DATA_WIDTH];
    if (out_rng) begin
`ifdef MUX_B_SEL_CHECK_EN
      sel_val = '0;
`else
      sel_val = src_in[DATA_WIDTH-1:0];
`endif
    end
  end

  assign req_ready = (state_q == IDLE)
                   || (state_q == HOLD && out_ready);
  assign acc = req_valid && req_ready;
  assign out_valid = (state_q == HOLD);
  assign mux_B_out = out_q;

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    mem_rd_en = 1'b0;
    cnt_ld    = 1'b0;
    cnt_dec   = 1'b0;
    unique case (state_q)
      IDLE, HOLD: begin
        if (acc) begin
          if (is_mem) begin
            mem_rd_en = 1'b1;
            cnt_ld    = 1'b1;
            state_d   = WAIT_MEM;
          end else begin
            out_d   = sel_val;
            state_d = HOLD;
          end
        end else if (state_q == HOLD && out_ready) begin
          state_d = IDLE;
        end
      end
      WAIT_MEM: begin
        if (cnt_zero) begin
          out_d   = mem_val;
          state_d = HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

`ifdef MUX_B_SEL_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (acc && out_rng) begin
      err_q <= 1'b1;
    end
  end

  assign sel_err = err_q;
`else
  assign sel_err = 1'b0;
`endif

  mux_b_lat_cnt #(
    .W(CW)
  ) u_lat_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_ld),
    .load_val_i(LD_VAL),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

endmodule

// File: tb/tb_mux_b_operand_sel.sv
// Directed bench for mux_b_operand_sel (3 sources, memory on src 1, latency 2).
// Expected values are hand-computed; sel_err expectation follows MUX_B_SEL_CHECK_EN.
module tb_mux_b_operand_sel;

  localparam int DW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] src0 = '0, src1 = '0, src2 = '0;
  logic [1:0]    sel_B = '0;
  logic          req_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          req_ready, mem_rd_en, out_valid, sel_err;
  logic [DW-1:0] mux_B_out;
  logic [3*DW-1:0] src_in;

  int vecs = 0;
  int errs = 0;

  assign src_in = {src2, src1, src0};

  always #5 clk = ~clk;

  mux_b_operand_sel #(
    .DATA_WIDTH (DW),
    .NUM_SRC    (3),
    .MEM_SRC    (1),
    .MEM_LATENCY(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_in   (src_in),
    .sel_B    (sel_B),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .mem_rd_en(mem_rd_en),
    .mux_B_out(mux_B_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sel_err  (sel_err)
  );

`ifdef MUX_B_SEL_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  task automatic test_reset_state();
    #1;
    vecs++;
    if ({req_ready, mem_rd_en, out_valid, sel_err} !== 4'b1000) begin
      errs++;
      $display("FAIL rst_flags got %b want 1000",
               {req_ready, mem_rd_en, out_valid, sel_err});
    end
    vecs++;
    if (mux_B_out !== '0) begin
      errs++;
      $display("FAIL rst_out got %h want 000", mux_B_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ext();
    @(negedge clk);
    src0 = 11'b00001100100;
    sel_B = 2'd0;
    req_valid = 1'b1;
    #1;
    vecs++;
    if ({req_ready, mem_rd_en} !== 2'b10) begin
      errs++;
      $display("FAIL ext_req got %b want 10", {req_ready, mem_rd_en});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    vecs++;
    if (mux_B_out !== 11'b00001100100 || out_valid !== 1'b1
        || mem_rd_en !== 1'b0) begin
      errs++;
      $display("FAIL ext_cap got %h/%b/%b want 064/1/0",
               mux_B_out, out_valid, mem_rd_en);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    vecs++;
    if (out_valid !== 1'b0 || mux_B_out !== 11'b00001100100) begin
      errs++;
      $display("FAIL ext_drain got %b/%h want 0/064", out_valid, mux_B_out);
    end
  endtask

  task automatic test_mem();
    @(negedge clk);
    src1 = 11'h7ff;
    sel_B = 2'd1;
    req_valid = 1'b1;
    #1;
    vecs++;
    if (mem_rd_en !== 1'b1 || req_ready !== 1'b1) begin
      errs++;
      $display("FAIL mem_strobe got %b/%b want 1/1", mem_rd_en, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    vecs++;
    if ({mem_rd_en, req_ready, out_valid} !== 3'b000) begin
      errs++;
      $display("FAIL mem_wait1 got %b want 000",
               {mem_rd_en, req_ready, out_valid});
    end
    @(posedge clk);
    #1;
    vecs++;
    if ({mem_rd_en, req_ready, out_valid} !== 3'b000) begin
      errs++;
      $display("FAIL mem_wait2 got %b want 000",
               {mem_rd_en, req_ready, out_valid});
    end
    src1 = 11'b11101001001;
    @(posedge clk);
    #1;
    vecs++;
    if (out_valid !== 1'b1 || mux_B_out !== 11'b11101001001) begin
      errs++;
      $display("FAIL mem_cap got %b/%h want 1/749", out_valid, mux_B_out);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      src0 = ~src0;
      src1 = ~src1;
      @(posedge clk);
      #1;
      vecs++;
      if (out_valid !== 1'b1 || mux_B_out !== 11'b11101001001) begin
        errs++;
        $display("FAIL hold_%0d got %b/%h want 1/749",
                 i, out_valid, mux_B_out);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    vecs++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
      errs++;
      $display("FAIL hold_rel got %b/%b want 0/1", out_valid, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    src0 = 11'h0aa;
    sel_B = 2'd0;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    src2 = 11'h155;
    sel_B = 2'd2;
    out_ready = 1'b1;
    #1;
    vecs++;
    if (req_ready !== 1'b1 || mux_B_out !== 11'h0aa) begin
      errs++;
      $display("FAIL b2b_rdy got %b/%h want 1/0aa", req_ready, mux_B_out);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    vecs++;
    if (mux_B_out !== 11'h155 || out_valid !== 1'b1) begin
      errs++;
      $display("FAIL b2b_cap got %h/%b want 155/1", mux_B_out, out_valid);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL b2b_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_sel_range();
    logic [DW-1:0] exp_out;
    exp_out = ERR_EXP ? 11'h000 : 11'h2ab;
    @(negedge clk);
    src0 = 11'h2ab;
    sel_B = 2'd3;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    vecs++;
    if (mux_B_out !== exp_out || out_valid !== 1'b1
        || sel_err !== ERR_EXP) begin
      errs++;
      $display("FAIL sel_oor got %h/%b/%b want %h/1/%b",
               mux_B_out, out_valid, sel_err, exp_out, ERR_EXP);
    end
    out_ready = 1'b1;
    sel_B = 2'd2;
    src2 = 11'h0f0;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    vecs++;
    if (mux_B_out !== 11'h0f0 || sel_err !== ERR_EXP) begin
      errs++;
      $display("FAIL sel_sticky got %h/%b want 0f0/%b",
               mux_B_out, sel_err, ERR_EXP);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_wait();
    @(negedge clk);
    src1 = 11'h321;
    sel_B = 2'd1;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    vecs++;
    if (req_ready !== 1'b0) begin
      errs++;
      $display("FAIL rw_wait got %b want 0", req_ready);
    end
    #1;
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({req_ready, mem_rd_en, out_valid, sel_err} !== 4'b1000
        || mux_B_out !== '0) begin
      errs++;
      $display("FAIL rw_async got %b/%h want 1000/000",
               {req_ready, mem_rd_en, out_valid, sel_err}, mux_B_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      vecs++;
      if (out_valid !== 1'b0 || mux_B_out !== '0) begin
        errs++;
        $display("FAIL rw_late_%0d got %b/%h want 0/000",
                 i, out_valid, mux_B_out);
      end
    end
  endtask

  initial begin
    test_reset_state();
    test_ext();
    test_mem();
    test_hold();
    test_back_to_back();
    test_sel_range();
    test_reset_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
